// File: rtl/sram_access_arbiter_pkg.sv
// Shared constants and helpers for the SRAM access arbiter and its round-robin sub-arbiter.
package sram_access_arbiter_pkg;

    localparam int STALL_CNT_W = 16;

    // Select-field width for n choices, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_access_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a registered pointer that moves past each winner.
module rr_arbiter
    import sram_access_arbiter_pkg::*;
#(
    parameter  int N     = 2,
    localparam int PTR_W = clog2_min1(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // NOTE: combinational logic uses blocking '=' with every output defaulted first, so no latch is inferred.
    always_comb begin
        logic [PTR_W-1:0] idx;
        gnt   = '0;
        ptr_d = ptr_q;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(ptr_q) + k) % N);
            if (gnt == '0 && req[idx]) begin
                gnt[idx] = 1'b1;
                ptr_d    = PTR_W'((int'(idx) + 1) % N);
            end
        end
        if (!advance) begin
            ptr_d = ptr_q;
        end
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares a multi-lane SRAM between requesters: round-robin write and read grants, tagged 1-cycle read responses.
// Optional per-requester stall counters when SRAM_ARB_STATS_EN is defined.
module sram_access_arbiter
    import sram_access_arbiter_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int ADDR_WIDTH = 8,
    parameter  int CHANNEL    = 2,
    parameter  int NUM_REQ    = 2,
    localparam int CH_W       = clog2_min1(CHANNEL)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             wr_valid,
    output logic [NUM_REQ-1:0]             wr_ready,
    input  logic [NUM_REQ*CH_W-1:0]        wr_ch,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  wr_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  wr_data_i,
    input  logic [NUM_REQ-1:0]             rd_valid,
    output logic [NUM_REQ-1:0]             rd_ready,
    input  logic [NUM_REQ*CH_W-1:0]        rd_ch,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  rd_addr_i,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic [CHANNEL-1:0]             wr_en,
    output logic [CHANNEL*ADDR_WIDTH-1:0]  wr_addr,
    output logic [CHANNEL*DATA_WIDTH-1:0]  wr_data,
    output logic [CHANNEL-1:0]             rd_en,
    output logic [CHANNEL*ADDR_WIDTH-1:0]  rd_addr,
`ifdef SRAM_ARB_STATS_EN
    output logic [NUM_REQ*STALL_CNT_W-1:0] stall_cnt,
`endif
    input  logic [CHANNEL*DATA_WIDTH-1:0]  rd_data
);

    localparam int              ID_W     = clog2_min1(NUM_REQ);
    localparam logic [CH_W:0]   CH_LIMIT = (CH_W + 1)'(CHANNEL);

    logic [CH_W-1:0]       wr_ch_a   [NUM_REQ];
    logic [CH_W-1:0]       rd_ch_a   [NUM_REQ];
    logic [ADDR_WIDTH-1:0] wr_addr_a [NUM_REQ];
    logic [ADDR_WIDTH-1:0] rd_addr_a [NUM_REQ];
    logic [DATA_WIDTH-1:0] wr_data_a [NUM_REQ];

    logic [NUM_REQ-1:0]    wr_req, rd_req, wr_gnt, rd_gnt;
    logic                  wr_any, rd_any;
    logic [ID_W-1:0]       wr_id, rd_id;
    logic [CH_W-1:0]       wr_sel_ch, rd_sel_ch;
    logic [ADDR_WIDTH-1:0] wr_sel_addr, rd_sel_addr;
    logic [DATA_WIDTH-1:0] wr_sel_data;

    logic                  tag_valid_q, tag_valid_d;
    logic [ID_W-1:0]       tag_id_q, tag_id_d;
    logic [CH_W-1:0]       tag_ch_q, tag_ch_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            wr_ch_a[i]   = wr_ch[i*CH_W +: CH_W];
            rd_ch_a[i]   = rd_ch[i*CH_W +: CH_W];
            wr_addr_a[i] = wr_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            rd_addr_a[i] = rd_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            wr_data_a[i] = wr_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Out-of-range channels are never eligible; nothing is granted while in reset.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            wr_req[i] = wr_valid[i] && ({1'b0, wr_ch_a[i]} < CH_LIMIT) && !rst;
        end
    end

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (wr_req),
        .advance (1'b1),
        .gnt     (wr_gnt)
    );

    always_comb begin
        wr_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_gnt[i]) wr_id = ID_W'(i);
        end
        wr_any      = |wr_gnt;
        wr_sel_ch   = wr_ch_a[wr_id];
        wr_sel_addr = wr_addr_a[wr_id];
        wr_sel_data = wr_data_a[wr_id];
    end

    // A read hitting the exact location being written this cycle waits, so it returns the new data.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rd_req[i] = rd_valid[i] && ({1'b0, rd_ch_a[i]} < CH_LIMIT) && !rst
                        && !(wr_any && rd_ch_a[i] == wr_sel_ch && rd_addr_a[i] == wr_sel_addr);
        end
    end

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (rd_req),
        .advance (1'b1),
        .gnt     (rd_gnt)
    );

    always_comb begin
        rd_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rd_gnt[i]) rd_id = ID_W'(i);
        end
        rd_any      = |rd_gnt;
        rd_sel_ch   = rd_ch_a[rd_id];
        rd_sel_addr = rd_addr_a[rd_id];
    end

    assign wr_ready = wr_gnt;
    assign rd_ready = rd_gnt;

    always_comb begin
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = '0;
        rd_addr = '0;
        if (wr_any) begin
            wr_en[wr_sel_ch]                                  = 1'b1;
            wr_addr[int'(wr_sel_ch)*ADDR_WIDTH +: ADDR_WIDTH] = wr_sel_addr;
            wr_data[int'(wr_sel_ch)*DATA_WIDTH +: DATA_WIDTH] = wr_sel_data;
        end
        if (rd_any) begin
            rd_en[rd_sel_ch]                                  = 1'b1;
            rd_addr[int'(rd_sel_ch)*ADDR_WIDTH +: ADDR_WIDTH] = rd_sel_addr;
        end
    end

    always_comb begin
        tag_valid_d = rd_any;
        tag_id_d    = rd_id;
        tag_ch_d    = rd_sel_ch;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_q <= 1'b0;
            tag_id_q    <= '0;
            tag_ch_q    <= '0;
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_id_q    <= tag_id_d;
            tag_ch_q    <= tag_ch_d;
        end
    end

    // Reset also squashes a response already in its return cycle.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (tag_valid_q && !rst) begin
            rsp_valid[tag_id_q] = 1'b1;
            rsp_data            = rd_data[int'(tag_ch_q)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef SRAM_ARB_STATS_EN
    logic [STALL_CNT_W-1:0] stall_q [NUM_REQ];
    logic [STALL_CNT_W-1:0] stall_d [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            stall_d[i] = stall_q[i];
            if ((wr_valid[i] || rd_valid[i]) && !(wr_gnt[i] || rd_gnt[i]) && stall_q[i] != '1) begin
                stall_d[i] = stall_q[i] + STALL_CNT_W'(1);
            end
            stall_cnt[i*STALL_CNT_W +: STALL_CNT_W] = stall_q[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                stall_q[i] <= '0;
            end else begin
                stall_q[i] <= stall_d[i];
            end
        end
    end
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ch_check
        assert property (@(posedge clk) disable iff (rst)
            wr_valid[g] |-> ({1'b0, wr_ch[g*CH_W +: CH_W]} < CH_LIMIT))
            else $fatal(1, "write request on nonexistent channel");
        assert property (@(posedge clk) disable iff (rst)
            rd_valid[g] |-> ({1'b0, rd_ch[g*CH_W +: CH_W]} < CH_LIMIT))
            else $fatal(1, "read request on nonexistent channel");
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level reference model and an SRAM model.
module tb_sram_access_arbiter;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int CH = 2;
    localparam int NR = 2;
    localparam int CW = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NR-1:0]     wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid;
    logic [NR*CW-1:0]  wr_ch, rd_ch;
    logic [NR*AW-1:0]  wr_addr_i, rd_addr_i;
    logic [NR*DW-1:0]  wr_data_i;
    logic [DW-1:0]     rsp_data;
    logic [CH-1:0]     wr_en, rd_en;
    logic [CH*AW-1:0]  wr_addr, rd_addr;
    logic [CH*DW-1:0]  wr_data, rd_data;
`ifdef SRAM_ARB_STATS_EN
    logic [NR*16-1:0]  stall_cnt;
`endif

    sram_access_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CHANNEL    (CH),
        .NUM_REQ    (NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_ch     (wr_ch),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_ch     (rd_ch),
        .rd_addr_i (rd_addr_i),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
`ifdef SRAM_ARB_STATS_EN
        .stall_cnt (stall_cnt),
`endif
        .rd_data   (rd_data)
    );

    // SRAM model: synchronous write, registered read data one cycle after rd_en.
    logic          mem_clr;
    logic [DW-1:0] mem [CH][256];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int c = 0; c < CH; c++)
                for (int a = 0; a < 256; a++) mem[c][a] <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (wr_en[c]) mem[c][wr_addr[c*AW +: AW]] <= wr_data[c*DW +: DW];
                if (rd_en[c]) rd_data[c*DW +: DW] <= mem[c][rd_addr[c*AW +: AW]];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state.
    int          wr_ptr, rd_ptr, wr_win, rd_win, rsp_id;
    bit          rsp_pend;
    logic [7:0]  rsp_dat;
    logic [7:0]  exp_mem [CH][256];
    int          stall [NR];

    function automatic int wch(input int i);   return int'(wr_ch[i*CW +: CW]);     endfunction
    function automatic int rch(input int i);   return int'(rd_ch[i*CW +: CW]);     endfunction
    function automatic int waddr(input int i); return int'(wr_addr_i[i*AW +: AW]); endfunction
    function automatic int raddr(input int i); return int'(rd_addr_i[i*AW +: AW]); endfunction
    function automatic int wdata(input int i); return int'(wr_data_i[i*DW +: DW]); endfunction

    // Settle after the falling edge, predict this cycle's outputs and compare.
    task automatic settle();
        logic [NR-1:0]    e_wrdy, e_rrdy, e_rsp;
        logic [CH-1:0]    e_wen, e_ren;
        logic [CH*AW-1:0] e_waddr, e_raddr;
        logic [CH*DW-1:0] e_wdata;
        logic [DW-1:0]    e_rdat;
        bit               clash;
        int               i;
        #1;
        e_wrdy = '0; e_rrdy = '0; e_rsp = '0; e_wen = '0; e_ren = '0;
        e_waddr = '0; e_raddr = '0; e_wdata = '0; e_rdat = '0;
        wr_win = -1;
        rd_win = -1;
        if (!rst) begin
            for (int k = 0; k < NR; k++) begin
                i = (wr_ptr + k) % NR;
                if (wr_win < 0 && wr_valid[i]) wr_win = i;
            end
            for (int k = 0; k < NR; k++) begin
                i = (rd_ptr + k) % NR;
                clash = (wr_win >= 0) && rch(i) == wch(wr_win) && raddr(i) == waddr(wr_win);
                if (rd_win < 0 && rd_valid[i] && !clash) rd_win = i;
            end
            if (wr_win >= 0) begin
                e_wrdy[wr_win]              = 1'b1;
                e_wen[wch(wr_win)]          = 1'b1;
                e_waddr[wch(wr_win)*AW +: AW] = AW'(waddr(wr_win));
                e_wdata[wch(wr_win)*DW +: DW] = DW'(wdata(wr_win));
            end
            if (rd_win >= 0) begin
                e_rrdy[rd_win]              = 1'b1;
                e_ren[rch(rd_win)]          = 1'b1;
                e_raddr[rch(rd_win)*AW +: AW] = AW'(raddr(rd_win));
            end
            if (rsp_pend) begin
                e_rsp[rsp_id] = 1'b1;
                e_rdat        = rsp_dat;
            end
        end
        check("wr_ready", wr_ready, e_wrdy);
        check("rd_ready", rd_ready, e_rrdy);
        check("wr_en", wr_en, e_wen);
        check("wr_addr", wr_addr, e_waddr);
        check("wr_data", wr_data, e_wdata);
        check("rd_en", rd_en, e_ren);
        check("rd_addr", rd_addr, e_raddr);
        check("rsp_valid", rsp_valid, e_rsp);
        check("rsp_data", rsp_data, e_rdat);
`ifdef SRAM_ARB_STATS_EN
        check("stall_cnt0", stall_cnt[15:0], 64'(stall[0]));
        check("stall_cnt1", stall_cnt[31:16], 64'(stall[1]));
`endif
    endtask

    // Apply the clock edge to the model, then wait for the next falling edge.
    task automatic advance();
        if (rst) begin
            wr_ptr = 0; rd_ptr = 0; rsp_pend = 0;
            for (int i = 0; i < NR; i++) stall[i] = 0;
        end else begin
            for (int i = 0; i < NR; i++)
                if ((wr_valid[i] || rd_valid[i]) && i != wr_win && i != rd_win && stall[i] < 65535)
                    stall[i]++;
            rsp_pend = (rd_win >= 0);
            if (rd_win >= 0) begin
                rsp_id  = rd_win;
                rsp_dat = exp_mem[rch(rd_win)][raddr(rd_win)];
                rd_ptr  = (rd_win + 1) % NR;
            end
            if (wr_win >= 0) begin
                exp_mem[wch(wr_win)][waddr(wr_win)] = DW'(wdata(wr_win));
                wr_ptr = (wr_win + 1) % NR;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        wr_valid = '0; rd_valid = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        settle();
        advance();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        for (int c = 0; c < CH; c++)
            for (int a = 0; a < 256; a++) exp_mem[c][a] = '0;
        wr_ch = '0; rd_ch = '0; wr_addr_i = '0; rd_addr_i = '0; wr_data_i = '0;
        wr_ptr = 0; rd_ptr = 0; rsp_pend = 0; rsp_id = 0; rsp_dat = '0;
        for (int i = 0; i < NR; i++) stall[i] = 0;
        mem_clr = 1'b1;
        rst = 1'b1;
        idle();
        @(negedge clk);
        settle();
        check("reset_rsp_valid", rsp_valid, 2'b00);
        advance();
        mem_clr = 1'b0;
        rst = 1'b0;

        // Write then read back through lane 1.
        wr_valid = 2'b01; wr_ch = 2'b01; wr_addr_i[7:0] = 8'h05; wr_data_i[7:0] = 8'hA5;
        settle();
        check("t1_wr_en", wr_en, 2'b10);
        check("t1_wr_addr_lane1", wr_addr[15:8], 8'h05);
        advance();
        idle();
        rd_valid = 2'b01; rd_ch = 2'b01; rd_addr_i[7:0] = 8'h05;
        settle();
        check("t1_rd_en", rd_en, 2'b10);
        advance();
        idle();
        settle();
        check("t1_rsp_valid", rsp_valid, 2'b01);
        check("t1_rsp_data", rsp_data, 8'hA5);
        advance();

        // Continuous reads from both requesters alternate.
        do_reset();
        rd_valid = 2'b11; rd_ch = 2'b10; rd_addr_i = 16'h0505;
        for (int c = 0; c < 6; c++) begin
            settle();
            check("t2_grant", rd_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
            if (c > 0) check("t2_rsp_valid", rsp_valid, (c % 2 == 1) ? 2'b01 : 2'b10);
            advance();
        end
        idle();
        settle();
        check("t2_last_rsp", rsp_valid, 2'b10);
        advance();

        // Same-location write/read: read waits one cycle and sees the new data.
        wr_valid = 2'b01; wr_ch = 2'b00; wr_addr_i[7:0] = 8'h10; wr_data_i[7:0] = 8'h3C;
        rd_valid = 2'b10; rd_ch = 2'b00; rd_addr_i[15:8] = 8'h10;
        settle();
        check("t3_rd_held", rd_ready, 2'b00);
        check("t3_wr_go", wr_ready, 2'b01);
        advance();
        wr_valid = 2'b00;
        settle();
        check("t3_rd_go", rd_ready, 2'b10);
        advance();
        idle();
        settle();
        check("t3_rsp_valid", rsp_valid, 2'b10);
        check("t3_rsp_data", rsp_data, 8'h3C);
        advance();

        // Same address, different lanes: both proceed.
        wr_valid = 2'b01; wr_ch = 2'b00; wr_addr_i[7:0] = 8'h10; wr_data_i[7:0] = 8'h77;
        rd_valid = 2'b10; rd_ch = 2'b10; rd_addr_i[15:8] = 8'h10;
        settle();
        check("t4_rd_en", rd_en, 2'b10);
        check("t4_wr_en", wr_en, 2'b01);
        advance();
        idle();
        settle();
        advance();

        // Reset with a read in flight: response dropped, pointers back to requester 0.
        rd_valid = 2'b01; rd_ch = 2'b00; rd_addr_i[7:0] = 8'h10;
        settle();
        check("t5_rd_grant", rd_ready, 2'b01);
        advance();
        rst = 1'b1;
        wr_valid = 2'b11; rd_valid = 2'b11; wr_ch = 2'b00; wr_addr_i = 16'h0201;
        settle();
        check("t5_rst_rsp_valid", rsp_valid, 2'b00);
        check("t5_rst_rsp_data", rsp_data, 8'h00);
        check("t5_rst_wr_ready", wr_ready, 2'b00);
        advance();
        rst = 1'b0;
        idle();
        settle();
        check("t5_post_rsp_valid", rsp_valid, 2'b00);
        check("t5_post_rd_en", rd_en, 2'b00);
        advance();
        wr_valid = 2'b11; rd_valid = 2'b11; rd_ch = 2'b10; rd_addr_i = 16'h3333;
        settle();
        check("t5_first_wr", wr_ready, 2'b01);
        check("t5_first_rd", rd_ready, 2'b01);
        advance();
        idle();
        settle();
        advance();

`ifdef SRAM_ARB_STATS_EN
        // Hazard-blocked read accumulates stall cycles for requester 1 only.
        do_reset();
        rd_valid = 2'b10; rd_ch = 2'b00; rd_addr_i[15:8] = 8'h20;
        for (int c = 0; c < 3; c++) begin
            wr_valid = 2'b01; wr_ch = 2'b00; wr_addr_i[7:0] = 8'h20; wr_data_i[7:0] = 8'(8'h40 + c);
            settle();
            advance();
        end
        wr_valid = 2'b00;
        settle();
        check("t6_stall_req1", stall_cnt[31:16], 16'd3);
        check("t6_stall_req0", stall_cnt[15:0], 16'd0);
        advance();
        idle();
        settle();
        advance();
`endif

        // Random traffic with a small address window to provoke hazards, plus sporadic resets.
        do_reset();
        wr_win = -1; rd_win = -1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                if (!wr_valid[i] || wr_win == i) begin
                    wr_valid[i]          = ($urandom_range(0, 3) != 0);
                    wr_ch[i*CW +: CW]     = CW'($urandom_range(0, CH - 1));
                    wr_addr_i[i*AW +: AW] = AW'($urandom_range(0, 3));
                    wr_data_i[i*DW +: DW] = DW'($urandom);
                end
                if (!rd_valid[i] || rd_win == i) begin
                    rd_valid[i]          = ($urandom_range(0, 3) != 0);
                    rd_ch[i*CW +: CW]     = CW'($urandom_range(0, CH - 1));
                    rd_addr_i[i*AW +: AW] = AW'($urandom_range(0, 3));
                end
            end
            rst = ($urandom_range(0, 49) == 0);
            settle();
            advance();
        end
        rst = 1'b0;
        idle();
        settle();
        advance();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
